// File: rtl/seq_detect_param.sv
// Serial pattern detector with run-time loadable pattern, length and overlap mode.
// Bits are shifted into a history register LSB-first; the low L history bits are
// compared against the low L pattern bits. Matches produce a registered one-cycle
// pulse and bump a saturating counter.
module seq_detect_param #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN_W-1:0] fill,
    output logic             armed,
    output logic             cfg_err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // FSM state
    logic [0:0]       state_q, state_d;

    // Captured configuration
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             ovl_q,   ovl_d;

    // Detection datapath
    logic [PAT_W-1:0] hist_q,  hist_d;
    logic [LEN_W-1:0] fill_q,  fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    // Combinational helpers
    logic             len_legal;
    logic             beat;
    logic [PAT_W-1:0] cmp_mask;
    logic [PAT_W-1:0] hist_sh;
    logic [LEN_W-1:0] fill_sh;
    logic             hit;

    // Qualify the incoming load length and the active-beat condition
    always_comb begin
        len_legal = (pat_len != '0) && (32'(pat_len) <= PAT_W);
        beat      = (state_q == S_ARMED) && din_valid;
    end

    // Build a mask of the low len_q bits used in the pattern comparison
    always_comb begin
        cmp_mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            cmp_mask[i] = (i < 32'(len_q));
        end
    end

    // Speculative shift of the current beat and match evaluation on the shifted view
    always_comb begin
        hist_sh = {hist_q[PAT_W-2:0], din};
        fill_sh = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : fill_q;
        hit     = (fill_sh >= len_q) && (((hist_sh ^ pat_q) & cmp_mask) == '0);
    end

    // Next-state for FSM, configuration, history, fill, match and error flag
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        err_d   = err_q;
        match_d = 1'b0;

        if (load) begin
            // Load wins over a coincident beat; that din bit is dropped.
            hist_d = '0;
            fill_d = '0;
            if (len_legal) begin
                pat_d   = pattern;
                len_d   = pat_len;
                ovl_d   = overlap;
                err_d   = 1'b0;
                state_d = S_ARMED;
            end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end else if (beat) begin
            match_d = hit;
            if (hit && !ovl_q) begin
                // Non-overlapping mode: forget the matched bits entirely.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_sh;
                fill_d = fill_sh;
            end
        end
    end

    // Saturating match counter; clear takes precedence over a coincident match
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Drive outputs straight from registers
    always_comb begin
        match     = match_q;
        match_cnt = cnt_q;
        fill      = fill_q;
        armed     = (state_q == S_ARMED);
        cfg_err   = err_q;
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based reference.
module tb_seq_detect_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, din, din_valid, load, overlap, clr_cnt;
    logic [7:0] pattern;
    logic [3:0] pat_len;

    logic       match_a, armed_a, err_a;
    logic [7:0] cnt_a;
    logic [3:0] fill_a;
    logic       match_b, armed_b, err_b;
    logic [1:0] cnt_b;
    logic [3:0] fill_b;

    seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .load(load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match_a), .match_cnt(cnt_a), .fill(fill_a), .armed(armed_a), .cfg_err(err_a)
    );

    seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .load(load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match_b), .match_cnt(cnt_b), .fill(fill_b), .armed(armed_b), .cfg_err(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the received bits since the last clear, oldest first.
    bit         q[$];
    bit         m_armed, m_err, m_ovl, m_match;
    logic [7:0] m_pat;
    int         m_len, m_cnt8, m_cnt2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit nm;
        nm = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_armed = 0; m_err = 0; m_ovl = 0; m_match = 0;
            m_pat = '0; m_len = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            if (load) begin
                if (pat_len >= 1 && pat_len <= 8) begin
                    m_pat = pattern; m_len = int'(pat_len); m_ovl = overlap;
                    m_armed = 1; m_err = 0;
                end else begin
                    m_armed = 0; m_err = 1;
                end
                q.delete();
            end else if (m_armed && din_valid) begin
                q.push_back(din);
                if (q.size() > m_len) void'(q.pop_front());
                if (q.size() == m_len) begin
                    nm = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (q[m_len-1-k] != m_pat[k]) nm = 1'b0;
                end
                if (nm && !m_ovl) q.delete();
            end
            m_match = nm;
            if (clr_cnt) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (nm) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
    endtask

    task automatic compare_all();
        chk("match",     match_a, m_match);
        chk("match_cnt", cnt_a,   m_cnt8);
        chk("fill",      fill_a,  q.size());
        chk("armed",     armed_a, m_armed);
        chk("cfg_err",   err_a,   m_err);
        chk("match_c2",  match_b, m_match);
        chk("cnt_c2",    cnt_b,   m_cnt2);
        chk("fill_c2",   fill_b,  q.size());
        chk("armed_c2",  armed_b, m_armed);
        chk("err_c2",    err_b,   m_err);
    endtask

    // One clock: drive inputs, advance model on the edge, compare at the falling edge.
    task automatic cycle(input bit r, input bit l, input bit dv, input bit d, input bit c);
        rst_n = r; load = l; din_valid = dv; din = d; clr_cnt = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();          cycle(1, 0, 0, 0, 0); endtask
    task automatic beat(input bit d); cycle(1, 0, 1, d, 0); endtask
    task automatic reset();         cycle(0, 0, 0, 0, 0); endtask
    task automatic loadcfg(input logic [7:0] p, input logic [3:0] len, input bit o);
        pattern = p; pat_len = len; overlap = o;
        cycle(1, 1, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; din = 0; din_valid = 0; load = 0; overlap = 0; clr_cnt = 0;
        pattern = '0; pat_len = '0;
        @(negedge clk);
        reset();
        reset();
        chk("rst_match", match_a, 0);
        chk("rst_cnt",   cnt_a,   0);
        chk("rst_fill",  fill_a,  0);
        chk("rst_armed", armed_a, 0);
        chk("rst_err",   err_a,   0);

        // Overlapping 101 over 1,0,1,0,1
        loadcfg(8'b101, 4'd3, 1'b1);
        chk("s1_armed", armed_a, 1);
        beat(1); beat(0); beat(1);
        chk("s1_m3", match_a, 1);
        chk("s1_model_m3", m_match, 1);
        beat(0);
        chk("s1_m4", match_a, 0);
        beat(1);
        chk("s1_m5", match_a, 1);
        chk("s1_cnt", cnt_a, 2);
        chk("s1_fill", fill_a, 3);
        chk("s1_model_cnt", m_cnt8, 2);

        // Non-overlapping 101 over 1,0,1,0,1
        reset();
        loadcfg(8'b101, 4'd3, 1'b0);
        beat(1); beat(0); beat(1);
        chk("s2_m3", match_a, 1);
        beat(0); beat(1);
        chk("s2_m5", match_a, 0);
        chk("s2_cnt", cnt_a, 1);
        chk("s2_fill", fill_a, 2);
        chk("s2_model_fill", q.size(), 2);

        // Illegal lengths
        reset();
        loadcfg(8'hFF, 4'd0, 1'b1);
        chk("s3_err0", err_a, 1);
        chk("s3_armed0", armed_a, 0);
        loadcfg(8'hFF, 4'd9, 1'b1);
        chk("s3_err9", err_a, 1);
        beat(1); beat(1); beat(1);
        chk("s3_match", match_a, 0);
        chk("s3_fill", fill_a, 0);
        chk("s3_armed", armed_a, 0);

        // Saturation with CNT_W=2 and clear coincident with a match
        reset();
        loadcfg(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat(1);
            chk("s4_cnt2", cnt_b, (i < 3) ? i + 1 : 3);
        end
        cycle(1, 0, 1, 1, 1);
        chk("s4_m6", match_b, 1);
        chk("s4_clr_c2", cnt_b, 0);
        chk("s4_clr_c8", cnt_a, 0);

        // Reset mid-sequence discards partial history
        reset();
        loadcfg(8'b101, 4'd3, 1'b1);
        beat(1); beat(0);
        reset();
        chk("s5_match", match_a, 0);
        chk("s5_cnt",   cnt_a,   0);
        chk("s5_fill",  fill_a,  0);
        chk("s5_armed", armed_a, 0);
        chk("s5_err",   err_a,   0);
        loadcfg(8'b101, 4'd3, 1'b1);
        beat(1);
        chk("s5_nomatch", match_a, 0);

        // Gaps between beats
        reset();
        loadcfg(8'b101, 4'd3, 1'b0);
        beat(1); idle();
        chk("s6_gap1", match_a, 0);
        beat(0); idle(); idle();
        chk("s6_gap2", match_a, 0);
        beat(1);
        chk("s6_hit", match_a, 1);
        idle();
        chk("s6_after1", match_a, 0);
        idle(); idle();
        chk("s6_after3", match_a, 0);

        // Randomized traffic
        reset();
        for (int n = 0; n < 4000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 199);
            pattern = 8'($urandom);
            pat_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10))
                                                  : 4'($urandom_range(1, 4));
            overlap = 1'($urandom);
            cycle((r != 0), (r < 8), ($urandom_range(0, 99) < 65), 1'($urandom),
                  ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter LEN_W, default 4, meaning width of pat_len and fill; 2**LEN_W > PAT_W required.
REQ-003 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port din  input  1  serial data bit.
REQ-007 SHALL have port din_valid  input  1  din sampled only when high.
REQ-008 SHALL have port load  input  1  capture pattern, pat_len, overlap into config registers.
REQ-009 SHALL have port pattern  input  PAT_W  target sequence; pattern[pat_len-1] is the first bit received, pattern[0] the last.
REQ-010 SHALL have port pat_len  input  LEN_W  pattern length in bits.
REQ-011 SHALL have port overlap  input  1  1 = overlapping matches allowed, 0 = restart after match.
REQ-012 SHALL have port clr_cnt  input  1  synchronous clear of match_cnt.
REQ-013 SHALL have port match  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating match count.
REQ-015 SHALL have port fill  output  LEN_W  number of valid history bits, capped at captured length.
REQ-016 SHALL have port armed  output  1  high in ARMED state.
REQ-017 SHALL have port cfg_err  output  1  sticky flag, last load had illegal length.

Function
REQ-018 SHALL implement states IDLE and ARMED; armed = (state == ARMED).
REQ-019 SHALL, on load with 1 <= pat_len <= PAT_W, capture config, clear history and fill, clear cfg_err, enter ARMED next cycle.
REQ-020 SHALL, on load with pat_len = 0 or pat_len > PAT_W, enter IDLE, set cfg_err, clear history and fill, leave config registers unchanged.
REQ-021 SHALL, in ARMED with din_valid high and load low, shift din into history LSB (hist <= {hist[PAT_W-2:0], din}) and increment fill, saturating at captured length.
REQ-022 SHALL compare the low L history bits (including the bit being shifted in) against pattern[L-1:0], L = captured length; a match requires shifted fill >= L.
REQ-023 SHALL assert match for exactly one cycle, the cycle after the completing din_valid beat; match is low whenever din_valid was low in the previous cycle.
REQ-024 SHALL, on match with overlap = 0, set fill to 0 and clear history so no bit of the matched sequence counts toward the next match.
REQ-025 SHALL, on match with overlap = 1, keep history and fill (fill stays L) so every subsequent beat is evaluated.
REQ-026 SHALL increment match_cnt by 1 per match and hold at 2**CNT_W-1 (no wrap).
REQ-027 SHALL clear match_cnt on clr_cnt; when clr_cnt and match coincide, clr_cnt wins (result 0).
REQ-028 SHALL give load priority over din_valid in the same cycle; that din bit is discarded and no match is generated.
REQ-029 SHALL ignore din/din_valid in IDLE: no shift, no match, fill held at 0.
REQ-030 SHALL keep config stable between loads; pattern, pat_len, overlap inputs are don't-care unless load is high.
REQ-031 SHALL keep match as a registered output with no combinational path from din or clk.

Reset
REQ-032 SHALL, when rst_n low at a rising clk edge, set state IDLE, match 0, match_cnt 0, fill 0, history 0, cfg_err 0, armed 0, config registers 0 (pat_len 0, overlap 0).
REQ-033 SHALL let reset override load, din_valid and clr_cnt in the same cycle; reset mid-sequence discards partial history.

Verification
REQ-034 SHALL cover: PAT_W=8, load pattern=8'b101, pat_len=3, overlap=1, beats 1,0,1,0,1 -> match pulses after beats 3 and 5, match_cnt=2, fill=3.
REQ-035 SHALL cover: same stimulus with overlap=0 -> single match after beat 3, match_cnt=1, fill=2 after beat 5.
REQ-036 SHALL cover: load pat_len=0, then pat_len=9 -> cfg_err=1, armed=0, beats 1,1,1 produce no match and fill=0.
REQ-037 SHALL cover: CNT_W=2, pattern 1'b1 len 1, 5 beats of 1 -> match_cnt 1,2,3,3,3; clr_cnt coincident with 6th match -> match_cnt=0.
REQ-038 SHALL cover: rst_n low after beats 1,0 of pattern 101 -> all outputs 0, armed=0; after reload, beat 1 alone yields no match.
REQ-039 SHALL cover: din_valid gaps of 1-3 idle cycles between beats 1,0,1 -> match exactly one cycle after final beat, none during gaps.
